// File: rtl/note_judge_if.sv
// Handshake/bus bundle between the note generator, player keys and the
// scoring back-end: tick/enable/note/keys in, score/status/pulses out.
interface note_judge_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          pulse;
   logic          en;
   logic [5:0]    note;
   logic [5:0]    keys;
   logic [7:0]    score;
   logic [5:0]    streak;
   logic          hit;
   logic          miss;
   logic [5:0]    head_note;
   logic [CW-1:0] count;
   logic          empty;
   logic          full;

   modport master (
      output pulse, en, note, keys,
      input  score, streak, hit, miss, head_note, count, empty, full
   );

   modport slave (
      input  pulse, en, note, keys,
      output score, streak, hit, miss, head_note, count, empty, full
   );
endinterface

// File: rtl/note_judge.sv
// Note game scoring back-end: queues generated notes, judges key presses
// against the oldest pending note, ages and expires unanswered notes.
// Ports: clk, nrst (async, active-low), bus_io (note_judge_if.slave):
//   in  pulse, en, note[5:0], keys[5:0]
//   out score[7:0], streak[5:0], hit, miss, head_note[5:0], count, empty, full
// Option: define NOTE_JUDGE_STREAK_BONUS_EN for +2 per hit once streak >= 8.
module note_judge #(
   parameter int DEPTH  = 4,
   parameter int WINDOW = 3
) (
   input logic        clk,
   input logic        nrst,
   note_judge_if.slave bus_io
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = $clog2(WINDOW) + 1;
   localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
   localparam logic [GW-1:0] AGE_LAST = GW'(WINDOW - 1);

   logic [5:0]    mem_q [DEPTH];
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [GW-1:0] age_q, age_d;
   logic [5:0]    keys_q, head_q, head_d;
   logic [7:0]    score_q, score_d;
   logic [5:0]    streak_q, streak_d;
   logic          hit_q, miss_q, empty_q, full_q;

   logic          press, tick, is_empty;
   logic          hit_c, bad_c, exp_c, pop_c, push_c, drop_c;
   logic [1:0]    inc_c;
   logic [8:0]    sum_c;

   assign tick     = bus_io.pulse & bus_io.en;
   assign press    = bus_io.en & (|(bus_io.keys & ~keys_q));
   assign is_empty = (cnt_q == '0);

   assign hit_c  = press & ~is_empty & (bus_io.keys == mem_q[rd_q]);
   assign bad_c  = press & ~is_empty & ~hit_c;
   // A correct press on the expiring tick wins: head leaves once, as a hit.
   assign exp_c  = tick & ~is_empty & (age_q == AGE_LAST) & ~hit_c;
   assign pop_c  = hit_c | exp_c;
   assign push_c = tick & ((cnt_q != FULL_C) | pop_c);
   assign drop_c = tick & ~push_c;

`ifdef NOTE_JUDGE_STREAK_BONUS_EN
   assign inc_c = (streak_q >= 6'd8) ? 2'd2 : 2'd1;
`else
   assign inc_c = 2'd1;
`endif

   assign sum_c = {1'b0, score_q} + {7'd0, inc_c};

   always_comb begin
      rd_d  = rd_q + AW'(pop_c);
      wr_d  = wr_q + AW'(push_c);
      cnt_d = cnt_q + CW'(push_c) - CW'(pop_c);

      age_d = age_q;
      if (pop_c || is_empty)
         age_d = '0;
      else if (tick)
         age_d = age_q + GW'(1);

      score_d = score_q;
      if (hit_c)
         score_d = sum_c[8] ? 8'hFF : sum_c[7:0];

      streak_d = streak_q;
      if (bad_c || exp_c || drop_c)
         streak_d = '0;
      else if (hit_c && streak_q != 6'd63)
         streak_d = streak_q + 6'd1;

      // The slot being written this cycle can become the new head
      // (push into empty, or pop leaving only the new note).
      head_d = mem_q[rd_d];
      if (cnt_d == '0)
         head_d = '0;
      else if (push_c && wr_q == rd_d)
         head_d = bus_io.note;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else if (push_c) begin
         mem_q[wr_q] <= bus_io.note;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rd_q     <= '0;
         wr_q     <= '0;
         cnt_q    <= '0;
         age_q    <= '0;
         keys_q   <= '0;
         head_q   <= '0;
         score_q  <= '0;
         streak_q <= '0;
         hit_q    <= 1'b0;
         miss_q   <= 1'b0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
      end else begin
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         cnt_q    <= cnt_d;
         age_q    <= age_d;
         keys_q   <= bus_io.keys;
         head_q   <= head_d;
         score_q  <= score_d;
         streak_q <= streak_d;
         hit_q    <= hit_c;
         miss_q   <= ~hit_c & (bad_c | exp_c | drop_c);
         empty_q  <= (cnt_d == '0);
         full_q   <= (cnt_d == FULL_C);
      end
   end

   assign bus_io.score     = score_q;
   assign bus_io.streak    = streak_q;
   assign bus_io.hit       = hit_q;
   assign bus_io.miss      = miss_q;
   assign bus_io.head_note = head_q;
   assign bus_io.count     = cnt_q;
   assign bus_io.empty     = empty_q;
   assign bus_io.full      = full_q;
endmodule

// File: tb/tb_note_judge.sv
// Randomized + directed bench for note_judge with a queue-based reference
// model feeding a scoreboard that a separate monitor drains each cycle.
module tb_note_judge;
   localparam int D = 4;
   localparam int W = 3;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   note_judge_if #(.DEPTH(D)) bus ();

   note_judge #(.DEPTH(D), .WINDOW(W)) dut (
      .clk    (clk),
      .nrst   (nrst),
      .bus_io (bus)
   );

   typedef struct {
      int score, streak, hit, miss, head, count, empty, full;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_pass = 0;

   // reference model state
   int mq[$];
   int age, kprev, m_score, m_streak;

   task automatic cmp(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   task automatic model_reset();
      mq.delete();
      age = 0; kprev = 0; m_score = 0; m_streak = 0;
   endtask

   task automatic model_step(input int p, input int e, input int n, input int k);
      exp_t x;
      bit press, tick, hit, bad, ex, drop;
      int inc;
      press = (e != 0) && ((k & ~kprev & 63) != 0);
      kprev = k;
      tick  = (p != 0) && (e != 0);
      hit   = press && mq.size() > 0 && k == mq[0];
      bad   = press && mq.size() > 0 && !hit;
      ex    = tick && mq.size() > 0 && age == W - 1 && !hit;
      drop  = 0;
      if (hit || ex) begin
         void'(mq.pop_front());
         age = 0;
      end else if (tick && mq.size() > 0) begin
         age++;
      end
      if (tick) begin
         if (mq.size() < D) mq.push_back(n);
         else drop = 1;
      end
      if (hit) begin
         inc = 1;
`ifdef NOTE_JUDGE_STREAK_BONUS_EN
         if (m_streak >= 8) inc = 2;
`endif
         m_score  = (m_score + inc > 255) ? 255 : m_score + inc;
         m_streak = (m_streak < 63) ? m_streak + 1 : 63;
      end
      if (bad || ex || drop) m_streak = 0;
      x.score  = m_score;
      x.streak = m_streak;
      x.hit    = hit;
      x.miss   = !hit && (bad || ex || drop);
      x.head   = mq.size() > 0 ? mq[0] : 0;
      x.count  = mq.size();
      x.empty  = mq.size() == 0;
      x.full   = mq.size() == D;
      exp_q.push_back(x);
   endtask

   // called at a negedge; returns at the next negedge
   task automatic drive(input int p, input int e, input int n, input int k);
      bus.pulse = p[0];
      bus.en    = e[0];
      bus.note  = n[5:0];
      bus.keys  = k[5:0];
      model_step(p, e, n, k);
      @(posedge clk);
      #2;
      @(negedge clk);
   endtask

   task automatic check_reset_vals(input string tag);
      cmp({tag, ".score"}, int'(bus.score), 0);
      cmp({tag, ".streak"}, int'(bus.streak), 0);
      cmp({tag, ".hit"}, int'(bus.hit), 0);
      cmp({tag, ".miss"}, int'(bus.miss), 0);
      cmp({tag, ".head"}, int'(bus.head_note), 0);
      cmp({tag, ".count"}, int'(bus.count), 0);
      cmp({tag, ".empty"}, int'(bus.empty), 1);
      cmp({tag, ".full"}, int'(bus.full), 0);
   endtask

   task automatic mid_reset();
      nrst = 1'b0;
      #1;
      check_reset_vals("async_rst");
      model_reset();
      @(negedge clk);
      nrst = 1'b1;
   endtask

   task automatic hit_once(input int n);
      drive(1, 1, n, 0);
      drive(0, 1, 0, n);
      drive(0, 1, 0, 0);
   endtask

   // monitor: pops one expectation per clock and checks every output
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            cmp("sb.score", int'(bus.score), x.score);
            cmp("sb.streak", int'(bus.streak), x.streak);
            cmp("sb.hit", int'(bus.hit), x.hit);
            cmp("sb.miss", int'(bus.miss), x.miss);
            cmp("sb.head", int'(bus.head_note), x.head);
            cmp("sb.count", int'(bus.count), x.count);
            cmp("sb.empty", int'(bus.empty), x.empty);
            cmp("sb.full", int'(bus.full), x.full);
         end
      end
   end

   initial begin
      int p, e, n, k, r;
      bus.pulse = 1'b0; bus.en = 1'b0; bus.note = '0; bus.keys = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      nrst = 1'b1;

      // single hit
      drive(1, 1, 6'h2D, 0);
      drive(0, 1, 0, 6'h2D);
      cmp("hit1.hit", int'(bus.hit), 1);
      cmp("hit1.score", int'(bus.score), 1);
      cmp("hit1.streak", int'(bus.streak), 1);
      cmp("hit1.count", int'(bus.count), 0);
      cmp("hit1.empty", int'(bus.empty), 1);
      drive(0, 1, 0, 0);
      cmp("hit1.pulse_len", int'(bus.hit), 0);

      // wrong press, then held keys
      drive(1, 1, 6'h2D, 0);
      drive(0, 1, 0, 6'h01);
      cmp("wrong.miss", int'(bus.miss), 1);
      cmp("wrong.streak", int'(bus.streak), 0);
      cmp("wrong.count", int'(bus.count), 1);
      cmp("wrong.head", int'(bus.head_note), 6'h2D);
      drive(0, 1, 0, 6'h01);
      cmp("held.miss", int'(bus.miss), 0);
      drive(0, 1, 0, 0);
      mid_reset();

      // expiry after WINDOW ticks
      for (int i = 1; i <= 4; i++) drive(1, 1, 6'h10 + i, 0);
      cmp("expire.miss", int'(bus.miss), 1);
      cmp("expire.head", int'(bus.head_note), 6'h12);
      cmp("expire.count", int'(bus.count), 3);
      mid_reset();

      // overflow drop
      for (int i = 1; i <= 5; i++) drive(1, 1, 6'h20 + i, 0);
      cmp("ovf.full", int'(bus.full), 1);
      drive(1, 1, 6'h26, 0);
      cmp("ovf.miss", int'(bus.miss), 1);
      cmp("ovf.count", int'(bus.count), 4);
      cmp("ovf.head", int'(bus.head_note), 6'h22);
      for (int i = 0; i < 12; i++) drive(1, 1, 6'h30, 0);
      mid_reset();

      // correct press on the expiring tick
      for (int i = 1; i <= 3; i++) drive(1, 1, 6'h30 + i, 0);
      drive(1, 1, 6'h34, 6'h31);
      cmp("race.hit", int'(bus.hit), 1);
      cmp("race.miss", int'(bus.miss), 0);
      cmp("race.count", int'(bus.count), 3);
      cmp("race.head", int'(bus.head_note), 6'h32);
      mid_reset();

      // nine consecutive hits, then saturation
      for (int i = 0; i < 9; i++) hit_once(1 + i);
`ifdef NOTE_JUDGE_STREAK_BONUS_EN
      cmp("hit9.score", int'(bus.score), 10);
`else
      cmp("hit9.score", int'(bus.score), 9);
`endif
      cmp("hit9.streak", int'(bus.streak), 9);
      for (int i = 0; i < 260; i++) hit_once(1 + $urandom_range(62));
      cmp("sat.score", int'(bus.score), 255);
      cmp("sat.streak", int'(bus.streak), 63);
      hit_once(6'h15);
      cmp("sat.hold", int'(bus.score), 255);
      mid_reset();

      // randomized run
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(499) == 0) mid_reset();
         e = ($urandom_range(9) != 0);
         p = ($urandom_range(2) == 0);
         n = $urandom_range(63);
         r = $urandom_range(9);
         if (r < 4) k = 0;
         else if (r < 7) k = (mq.size() > 0) ? mq[0] : 0;
         else k = $urandom_range(63);
         drive(p, e, n, k);
      end

      drive(0, 1, 0, 0);
      cmp("sb.drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
